// File: rtl/darkmemsched_if.sv
// Bundle of per-core request buses, shared read data and the single memory port.
// master = scheduler side (drives PAB_*, DATAI, HLT, GRANT, TMO_ERR).
// slave  = cores plus memory side (drives requests and memory responses).
interface darkmemsched_if #(
  parameter int NCORES = 2
);
  logic [NCORES*32-1:0] DADDR;
  logic [NCORES*32-1:0] DATAO;
  logic [NCORES-1:0]    WR;
  logic [NCORES-1:0]    RD;
  logic [NCORES*4-1:0]  BE;
  logic [31:0]          DATAI;
  logic [NCORES-1:0]    HLT;
  logic [NCORES-1:0]    GRANT;
  logic [31:0]          PAB_ADDR;
  logic [31:0]          PAB_DATA;
  logic [3:0]           PAB_BE;
  logic                 PAB_RD;
  logic                 PAB_WR;
  logic                 PAB_VALID;
  logic                 MEM_READY;
  logic                 MEM_VALID;
  logic [31:0]          MEM_DATA;
  logic                 TMO_ERR;

  modport master (
    input  DADDR, DATAO, WR, RD, BE, MEM_READY, MEM_VALID, MEM_DATA,
    output DATAI, HLT, GRANT, PAB_ADDR, PAB_DATA, PAB_BE, PAB_RD, PAB_WR,
           PAB_VALID, TMO_ERR
  );

  modport slave (
    output DADDR, DATAO, WR, RD, BE, MEM_READY, MEM_VALID, MEM_DATA,
    input  DATAI, HLT, GRANT, PAB_ADDR, PAB_DATA, PAB_BE, PAB_RD, PAB_WR,
           PAB_VALID, TMO_ERR
  );
endinterface

// File: rtl/darkmemsched.sv
// Round-robin arbiter sharing one memory port among NCORES cores, one transaction in flight.
// Latency: request seen in IDLE -> DONE three cycles later at best; watchdog caps REQ+WAIT at TMO cycles.
// Backpressure: PAB_VALID held with stable PAB_* until MEM_READY; waiting cores are stalled through HLT.
module darkmemsched #(
  parameter int NCORES = 2,
  parameter int TMO    = 15
) (
  input logic           XCLK,
  input logic           XRES,
  darkmemsched_if.master bus
);
  localparam int IW = (NCORES > 1) ? $clog2(NCORES) : 1;

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_DONE} state_t;

  state_t            state, state_nxt;
  logic [IW-1:0]     ptr, owner, owner_inc, sel_idx;
  logic              sel_found;
  logic [NCORES-1:0] req, hlt, grant, sel_onehot;
  logic [31:0]       sel_addr, sel_data;
  logic [3:0]        sel_be;
  logic              sel_rd, sel_wr;
  logic [7:0]        wdog;
  logic              timeout;
  logic              pab_valid;
  logic [31:0]       pab_addr, pab_data, datai;
  logic [3:0]        pab_be;
  logic              pab_rd, pab_wr, tmo_err;

  assign req       = bus.RD | bus.WR;
  assign timeout   = (wdog == 8'(TMO - 1));
  assign owner_inc = (owner == IW'(NCORES - 1)) ? '0 : owner + 1'b1;

  assign bus.HLT       = hlt;
  assign bus.GRANT     = grant;
  assign bus.PAB_VALID = pab_valid;
  assign bus.PAB_ADDR  = pab_addr;
  assign bus.PAB_DATA  = pab_data;
  assign bus.PAB_BE    = pab_be;
  assign bus.PAB_RD    = pab_rd;
  assign bus.PAB_WR    = pab_wr;
  assign bus.DATAI     = datai;
  assign bus.TMO_ERR   = tmo_err;

  // Stall every requester except the owner during its single DONE cycle.
  always_comb begin
    hlt = '0;
    for (int j = 0; j < NCORES; j++) begin
      hlt[j] = req[j] & ~((state == S_DONE) && (owner == IW'(j)));
    end
  end

  // Pick the first requester scanning upward from ptr, wrapping around.
  always_comb begin
    sel_found = 1'b0;
    sel_idx   = '0;
    for (int i = 0; i < NCORES; i++) begin
      for (int j = 0; j < NCORES; j++) begin
        if (!sel_found && req[j] && (((int'(ptr) + i) % NCORES) == j)) begin
          sel_found = 1'b1;
          sel_idx   = IW'(j);
        end
      end
    end
  end

  // Mux out the selected core's request fields.
  always_comb begin
    sel_addr   = '0;
    sel_data   = '0;
    sel_be     = '0;
    sel_rd     = 1'b0;
    sel_wr     = 1'b0;
    sel_onehot = '0;
    for (int j = 0; j < NCORES; j++) begin
      if (sel_idx == IW'(j)) begin
        sel_addr      = bus.DADDR[32*j +: 32];
        sel_data      = bus.DATAO[32*j +: 32];
        sel_be        = bus.BE[4*j +: 4];
        sel_rd        = bus.RD[j];
        sel_wr        = bus.WR[j];
        sel_onehot[j] = 1'b1;
      end
    end
  end

  // State register.
  always_ff @(posedge XCLK) begin
    if (XRES) state <= S_IDLE;
    else      state <= state_nxt;
  end

  // Next state and request-valid; a real accept/response beats a same-cycle timeout.
  always_comb begin
    state_nxt = state;
    pab_valid = 1'b0;
    case (state)
      S_IDLE: if (sel_found) state_nxt = S_REQ;
      S_REQ: begin
        pab_valid = 1'b1;
        if (bus.MEM_READY)  state_nxt = S_WAIT;
        else if (timeout)   state_nxt = S_DONE;
      end
      S_WAIT: begin
        if (bus.MEM_VALID)  state_nxt = S_DONE;
        else if (timeout)   state_nxt = S_DONE;
      end
      S_DONE: state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Transaction datapath: latch the winner, run the watchdog, capture read data, rotate ptr.
  always_ff @(posedge XCLK) begin
    if (XRES) begin
      ptr      <= '0;
      owner    <= '0;
      grant    <= '0;
      pab_addr <= '0;
      pab_data <= '0;
      pab_be   <= '0;
      pab_rd   <= 1'b0;
      pab_wr   <= 1'b0;
      datai    <= '0;
      tmo_err  <= 1'b0;
      wdog     <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (sel_found) begin
            owner    <= sel_idx;
            grant    <= sel_onehot;
            pab_addr <= sel_addr;
            pab_data <= sel_data;
            pab_be   <= sel_be;
            pab_rd   <= sel_rd;
            pab_wr   <= sel_wr;
            wdog     <= '0;
          end
        end
        S_REQ: begin
          wdog <= wdog + 8'd1;
          if (!bus.MEM_READY && timeout) begin
            tmo_err <= 1'b1;
            if (pab_rd) datai <= 32'hFFFF_FFFF;
          end
        end
        S_WAIT: begin
          wdog <= wdog + 8'd1;
          if (bus.MEM_VALID) begin
            if (pab_rd) datai <= bus.MEM_DATA;
          end else if (timeout) begin
            tmo_err <= 1'b1;
            if (pab_rd) datai <= 32'hFFFF_FFFF;
          end
        end
        S_DONE: begin
          ptr    <= owner_inc;
          grant  <= '0;
          pab_rd <= 1'b0;
          pab_wr <= 1'b0;
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_darkmemsched.sv
// Directed bench for darkmemsched with a transaction-level reference model.
// The model tracks busy/accepted/finishing flags and an age counter per transaction.
// A negedge compare process checks every output each cycle; directed steps add literal checks.
module tb_darkmemsched;
  localparam int N   = 2;
  localparam int TMO = 15;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  darkmemsched_if #(.NCORES(N)) bus();

  darkmemsched #(.NCORES(N), .TMO(TMO)) dut (
    .XCLK(clk),
    .XRES(rst),
    .bus (bus.master)
  );

  int n_cmp = 0;
  int n_bad = 0;
  bit chk_en = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  bit          m_busy, m_acc, m_fin, m_rd, m_wr, m_err;
  int          m_own, m_ptr, m_age;
  logic [31:0] m_addr, m_data, m_datai;
  logic [3:0]  m_be;
  int          nxt_pick;

  function automatic int pick(input int start, input logic [N-1:0] r);
    for (int k = 0; k < N; k++)
      if (r[(start + k) % N]) return (start + k) % N;
    return -1;
  endfunction

  function automatic logic [N-1:0] exp_hlt(input logic [N-1:0] r, input bit fin, input int own);
    logic [N-1:0] h;
    h = r;
    if (fin) h[own] = 1'b0;
    return h;
  endfunction

  function automatic logic [N-1:0] exp_grant(input bit busy, input int own);
    logic [N-1:0] g;
    g = '0;
    if (busy) g[own] = 1'b1;
    return g;
  endfunction

  always_comb nxt_pick = pick(m_ptr, bus.RD | bus.WR);

  always @(posedge clk) begin
    if (rst) begin
      m_busy <= 0; m_acc <= 0; m_fin <= 0; m_rd <= 0; m_wr <= 0; m_err <= 0;
      m_own <= 0; m_ptr <= 0; m_age <= 0;
      m_addr <= '0; m_data <= '0; m_be <= '0; m_datai <= '0;
    end else if (m_fin) begin
      m_fin <= 0; m_busy <= 0; m_rd <= 0; m_wr <= 0;
      m_ptr <= (m_own + 1) % N;
    end else if (m_busy) begin
      m_age <= m_age + 1;
      if (!m_acc && bus.MEM_READY) m_acc <= 1;
      else if (m_acc && bus.MEM_VALID) begin
        m_fin <= 1;
        if (m_rd) m_datai <= bus.MEM_DATA;
      end else if (m_age == TMO - 1) begin
        m_fin <= 1;
        m_err <= 1;
        if (m_rd) m_datai <= 32'hFFFF_FFFF;
      end
    end else if (nxt_pick >= 0) begin
      m_busy <= 1; m_acc <= 0; m_age <= 0;
      m_own  <= nxt_pick;
      m_addr <= bus.DADDR[32*nxt_pick +: 32];
      m_data <= bus.DATAO[32*nxt_pick +: 32];
      m_be   <= bus.BE[4*nxt_pick +: 4];
      m_rd   <= bus.RD[nxt_pick];
      m_wr   <= bus.WR[nxt_pick];
    end
  end

  // Per-cycle comparison against the model.
  always @(negedge clk) begin
    if (chk_en) begin
      chk("GRANT",     32'(bus.GRANT),     32'(exp_grant(m_busy, m_own)));
      chk("HLT",       32'(bus.HLT),       32'(exp_hlt(bus.RD | bus.WR, m_fin, m_own)));
      chk("PAB_VALID", 32'(bus.PAB_VALID), 32'(m_busy && !m_acc && !m_fin));
      chk("PAB_ADDR",  bus.PAB_ADDR,       m_addr);
      chk("PAB_DATA",  bus.PAB_DATA,       m_data);
      chk("PAB_BE",    32'(bus.PAB_BE),    32'(m_be));
      chk("PAB_RD",    32'(bus.PAB_RD),    32'(m_rd));
      chk("PAB_WR",    32'(bus.PAB_WR),    32'(m_wr));
      chk("DATAI",     bus.DATAI,          m_datai);
      chk("TMO_ERR",   32'(bus.TMO_ERR),   32'(m_err));
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic tick();
    @(posedge clk);
    #3;
  endtask

  task automatic wait_grant(input string name);
    int c;
    c = 0;
    while (bus.GRANT == '0 && c < 40) begin tick(); c++; end
    n_cmp++;
    if (bus.GRANT == '0) begin
      n_bad++;
      $display("FAIL %s: no grant within %0d cycles", name, c);
    end
  endtask

  task automatic wait_done(input int core, input string name, output int cyc);
    cyc = 0;
    while (!(bus.GRANT[core] && !bus.HLT[core]) && cyc < 40) begin tick(); cyc++; end
    n_cmp++;
    if (!(bus.GRANT[core] && !bus.HLT[core])) begin
      n_bad++;
      $display("FAIL %s: no DONE within %0d cycles", name, cyc);
    end
  endtask

  task automatic wait_idle(input string name);
    int c;
    c = 0;
    while (bus.GRANT != '0 && c < 40) begin tick(); c++; end
    n_cmp++;
    if (bus.GRANT != '0) begin
      n_bad++;
      $display("FAIL %s: grant never dropped", name);
    end
  endtask

  initial begin
    int n;
    bus.DADDR = '0; bus.DATAO = '0; bus.WR = '0; bus.RD = '0; bus.BE = '0;
    bus.MEM_READY = 1'b0; bus.MEM_VALID = 1'b0; bus.MEM_DATA = '0;
    rst = 1'b1;
    tick();
    chk_en = 1'b1;
    tick();
    chk("rst_grant", 32'(bus.GRANT), 32'h0);
    chk("rst_valid", 32'(bus.PAB_VALID), 32'h0);
    chk("rst_datai", bus.DATAI, 32'h0);
    chk("rst_tmo",   32'(bus.TMO_ERR), 32'h0);
    rst = 1'b0;
    tick();

    // Single read, fastest path.
    bus.RD[0] = 1'b1; bus.DADDR[31:0] = 32'h10; bus.BE[3:0] = 4'hF;
    bus.MEM_READY = 1'b1; bus.MEM_DATA = 32'hCAFE_0001;
    #1 chk("s1_hlt_c0", 32'(bus.HLT[0]), 32'h1);
    tick();
    chk("s1_valid_c1", 32'(bus.PAB_VALID), 32'h1);
    chk("s1_addr_c1",  bus.PAB_ADDR, 32'h10);
    chk("s1_grant_c1", 32'(bus.GRANT), 32'h1);
    tick();
    chk("s1_valid_c2", 32'(bus.PAB_VALID), 32'h0);
    chk("s1_hlt_c2",   32'(bus.HLT[0]), 32'h1);
    bus.MEM_VALID = 1'b1;
    tick();
    chk("s1_hlt_c3",   32'(bus.HLT[0]), 32'h0);
    chk("s1_datai_c3", bus.DATAI, 32'hCAFE_0001);
    bus.MEM_VALID = 1'b0; bus.RD[0] = 1'b0;
    tick();
    chk("s1_grant_c4", 32'(bus.GRANT), 32'h0);

    // Contention from reset: core 0 reads, core 1 writes, strict alternation.
    rst = 1'b1;
    bus.RD[0] = 1'b1; bus.WR[1] = 1'b1;
    bus.DADDR[31:0] = 32'h100; bus.DADDR[63:32] = 32'h200;
    bus.DATAO[63:32] = 32'hA5A5_0001; bus.BE[7:4] = 4'h3;
    bus.MEM_READY = 1'b1; bus.MEM_VALID = 1'b1; bus.MEM_DATA = 32'h1234_5678;
    tick();
    rst = 1'b0;
    for (int t = 0; t < 4; t++) begin
      wait_grant("s2_grant_wait");
      chk("s2_order", 32'(bus.GRANT), (t % 2 == 0) ? 32'h1 : 32'h2);
      if (bus.GRANT == 2'b10) begin
        chk("s2_wr_be",   32'(bus.PAB_BE), 32'h3);
        chk("s2_wr_data", bus.PAB_DATA, 32'hA5A5_0001);
        chk("s2_wr_flag", 32'(bus.PAB_WR), 32'h1);
      end
      wait_idle("s2_idle_wait");
    end
    bus.RD[0] = 1'b0; bus.WR[1] = 1'b0; bus.MEM_VALID = 1'b0;
    chk("s2_datai", bus.DATAI, 32'h1234_5678);

    // Backpressure: four cycles without MEM_READY in REQ.
    bus.WR[0] = 1'b1; bus.DADDR[31:0] = 32'h40; bus.DATAO[31:0] = 32'h55; bus.BE[3:0] = 4'hC;
    bus.MEM_READY = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      tick();
      chk("s3_valid_hold", 32'(bus.PAB_VALID), 32'h1);
      chk("s3_addr_hold",  bus.PAB_ADDR, 32'h40);
    end
    tick();
    chk("s3_valid_c5", 32'(bus.PAB_VALID), 32'h1);
    bus.MEM_READY = 1'b1;
    tick();
    chk("s3_valid_c6", 32'(bus.PAB_VALID), 32'h0);
    bus.MEM_READY = 1'b0; bus.MEM_VALID = 1'b1;
    tick();
    chk("s3_hlt_done", 32'(bus.HLT[0]), 32'h0);
    chk("s3_datai",    bus.DATAI, 32'h1234_5678);
    bus.WR[0] = 1'b0; bus.MEM_VALID = 1'b0;
    tick();

    // Watchdog: memory accepts but never responds.
    bus.RD[1] = 1'b1; bus.DADDR[63:32] = 32'h80; bus.MEM_READY = 1'b1;
    tick();
    chk("s4_grant", 32'(bus.GRANT), 32'h2);
    wait_done(1, "s4_wdog_wait", n);
    chk("s4_wdog_cycles", 32'(n), 32'd15);
    chk("s4_datai", bus.DATAI, 32'hFFFF_FFFF);
    chk("s4_tmo",   32'(bus.TMO_ERR), 32'h1);
    bus.RD[1] = 1'b0;
    tick();
    bus.RD[0] = 1'b1; bus.MEM_VALID = 1'b1; bus.MEM_DATA = 32'hBEEF_0002;
    wait_grant("s4_next_grant");
    wait_done(0, "s4_next_done", n);
    chk("s4_next_datai", bus.DATAI, 32'hBEEF_0002);
    chk("s4_tmo_sticky", 32'(bus.TMO_ERR), 32'h1);
    bus.RD[0] = 1'b0; bus.MEM_VALID = 1'b0;
    tick();

    // Reset while in WAIT.
    bus.RD[1] = 1'b1; bus.DADDR[63:32] = 32'h300; bus.MEM_READY = 1'b1;
    tick();
    chk("s6_grant_req", 32'(bus.GRANT), 32'h2);
    tick();
    chk("s6_valid_wait", 32'(bus.PAB_VALID), 32'h0);
    rst = 1'b1;
    tick();
    chk("s6_grant", 32'(bus.GRANT), 32'h0);
    chk("s6_addr",  bus.PAB_ADDR, 32'h0);
    chk("s6_datai", bus.DATAI, 32'h0);
    chk("s6_tmo",   32'(bus.TMO_ERR), 32'h0);
    chk("s6_hlt",   32'(bus.HLT), 32'h2);
    rst = 1'b0; bus.RD[0] = 1'b1; bus.DADDR[31:0] = 32'h20;
    bus.MEM_VALID = 1'b1; bus.MEM_DATA = 32'hDEAD_0003;
    tick();
    chk("s6_first_grant", 32'(bus.GRANT), 32'h1);
    chk("s6_late_ignored", bus.DATAI, 32'h0);
    bus.MEM_VALID = 1'b0;
    tick();
    bus.MEM_VALID = 1'b1; bus.MEM_DATA = 32'h600D_0004;
    tick();
    chk("s6_datai_done", bus.DATAI, 32'h600D_0004);
    bus.RD[0] = 1'b0;
    tick();
    wait_grant("s6_core1_grant");
    wait_done(1, "s6_core1_done", n);
    bus.RD[1] = 1'b0; bus.MEM_VALID = 1'b0;
    tick();

    // Response arrives on the exact timeout cycle.
    bus.RD[0] = 1'b1; bus.DADDR[31:0] = 32'h500; bus.MEM_READY = 1'b1;
    bus.MEM_DATA = 32'h0BAD_F00D;
    tick();
    chk("s5_grant", 32'(bus.GRANT), 32'h1);
    repeat (14) tick();
    chk("s5_still_busy", 32'(bus.HLT[0]), 32'h1);
    bus.MEM_VALID = 1'b1;
    tick();
    chk("s5_hlt_done", 32'(bus.HLT[0]), 32'h0);
    chk("s5_datai",    bus.DATAI, 32'h0BAD_F00D);
    chk("s5_tmo",      32'(bus.TMO_ERR), 32'h0);
    bus.RD[0] = 1'b0; bus.MEM_VALID = 1'b0;
    tick();
    tick();

    chk_en = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: bench did not complete");
    $fatal(1);
  end
endmodule
